// File: rtl/xm23_pkg.sv
// Shared definitions for the execute-stage branch resolver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xm23_pkg;

    // PSW flag bit positions
    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 4;

    // Opcode prefixes (three msbs of the instruction)
    localparam logic [2:0] OP_BL    = 3'b000;
    localparam logic [2:0] OP_BCOND = 3'b001;

    // Branch condition field encodings, instr[12:10]
    typedef enum logic [2:0] {
        COND_EQ = 3'b000,
        COND_NE = 3'b001,
        COND_HS = 3'b010,
        COND_LO = 3'b011,
        COND_MI = 3'b100,
        COND_GE = 3'b101,
        COND_LT = 3'b110,
        COND_AL = 3'b111
    } branch_cond_e;

    // Resolver FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_FLUSH    = 2'b10
    } res_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a branch condition against a saved PSW; taken=1 when the condition holds.
// Latency: combinational.
// Backpressure: none.
module branch_cond_eval
    import xm23_pkg::*;
(
    input  logic [2:0]  cond,
    input  logic [15:0] psw,
    output logic        taken
);

    logic c_flag;
    logic z_flag;
    logic n_flag;
    logic v_flag;
    logic unused_psw_bits;

    assign c_flag = psw[PSW_C];
    assign z_flag = psw[PSW_Z];
    assign n_flag = psw[PSW_N];
    assign v_flag = psw[PSW_V];

    // Remaining PSW bits carry no condition information.
    assign unused_psw_bits = ^{psw[15:5], psw[3]};

    // Condition decode
    always_comb begin
        taken = 1'b0;
        case (branch_cond_e'(cond))
            COND_EQ: taken = z_flag;
            COND_NE: taken = ~z_flag;
            COND_HS: taken = c_flag;
            COND_LO: taken = ~c_flag;
            COND_MI: taken = n_flag;
            COND_GE: taken = (n_flag == v_flag);
            COND_LT: taken = (n_flag != v_flag);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves always-taken predictions in execute: redirects on mispredict, writes LR for BL, counts stats.
// Latency: all outputs registered; redirect_valid/lr_we rise 1 cycle after the branch is in execute.
// Backpressure: redirect held stable in REDIRECT until redirect_ready; execute ignored while busy.
module branch_resolver
    import xm23_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_bl,
    input  logic             ex_is_bcond,
    input  logic [2:0]       ex_cond,
    input  logic [15:0]      psw_saved,
    input  logic [15:0]      fallthrough_pc,
    input  logic [15:0]      lr_value,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [15:0]      redirect_pc,
    output logic             flush,
    output logic             lr_we,
    output logic [15:0]      lr_data,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // FLUSH state lasts FLUSH_DEPTH-1 cycles after the redirect is accepted.
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    res_state_e       state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [15:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic             lr_we_q, lr_we_d;
    logic [15:0]      lr_data_q, lr_data_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic cond_taken;
    logic resolve_bl;
    logic resolve_bcond;

    branch_cond_eval u_cond_eval (
        .cond  (ex_cond),
        .psw   (psw_saved),
        .taken (cond_taken)
    );

    // BL takes priority when both decode flags are set.
    assign resolve_bl    = ex_valid & ex_is_bl;
    assign resolve_bcond = ex_valid & ex_is_bcond & ~ex_is_bl;

    // Next-state, statistics and registered-output computation
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        lr_we_d       = 1'b0;
        lr_data_d     = lr_data_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (resolve_bl) begin
                    lr_we_d   = 1'b1;
                    lr_data_d = lr_value;
                    if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_W'(1);
                end else if (resolve_bcond) begin
                    if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_W'(1);
                    if (!cond_taken) begin
                        redirect_pc_d = fallthrough_pc;
                        state_d       = ST_REDIRECT;
                        if (mispred_cnt_q != CNT_MAX) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_DEPTH > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = 3'd0;
            end
        endcase

        // Status outputs are decoded from the next state so they register in step with it.
        redirect_valid_d = (state_d == ST_REDIRECT);
        flush_d          = (state_d != ST_IDLE);
        busy_d           = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= 3'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'h0000;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            lr_we_q          <= 1'b0;
            lr_data_q        <= 16'h0000;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
            lr_we_q          <= lr_we_d;
            lr_data_q        <= lr_data_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign lr_we          = lr_we_q;
    assign lr_data        = lr_data_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule
